rate_tick_gen: RTL and testbench



---
 rtl/timer_pkg.sv | 26 ++
 rtl/mod_counter.sv | 42 ++++
 rtl/rate_tick_gen.sv | 94 +++++++++
 tb/tb_rate_tick_gen.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared constants and helpers for the rate/timer blocks.
// Defaults here are the UART-oriented baud and oversample settings.
package timer_pkg;

  localparam int TIMER_DEFAULT_PERIOD = 434;
  localparam int TIMER_DEFAULT_OVS    = 16;
  localparam int MIN_PERIOD           = 2;

  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result    = result + 1;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

  // A counter always needs at least one bit, even when OVS is 1.
  function automatic int ovs_width(input int ovs);
    return (clog2(ovs) < 1) ? 1 : clog2(ovs);
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Wrap-at-limit counter with enable, synchronous clear and a registered wrap pulse.
// It counts 0..i_last and pulses o_wrap in the cycle after the wrapping edge.
module mod_counter #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  input  logic         i_clr,
  input  logic [W-1:0] i_last,
  output logic         o_at_last,
  output logic         o_wrap
);

  logic [W-1:0] r_count;
  logic         r_wrap;

  // Using >= keeps the counter bounded even if i_last drops below a held count.
  assign o_at_last = (r_count >= i_last);
  assign o_wrap    = r_wrap;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
    end else if (i_clr) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
    end else if (i_en) begin
      if (o_at_last) begin
        r_count <= '0;
        r_wrap  <= 1'b1;
      end else begin
        r_count <= r_count + 1'b1;
        r_wrap  <= 1'b0;
      end
    end else begin
      r_wrap <= 1'b0;
    end
  end

endmodule

// File: rtl/rate_tick_gen.sv
// Programmable rate-tick generator: a tick every period_cur enabled clocks and an
// ovs_tick every OVS ticks, with period changes taking effect only at safe points.
module rate_tick_gen
  import timer_pkg::*;
#(
  parameter int CNT_W          = 20,
  parameter int DEFAULT_PERIOD = TIMER_DEFAULT_PERIOD,
  parameter int OVS            = TIMER_DEFAULT_OVS,
  parameter int OVS_W          = ovs_width(OVS)
) (
  input  logic             clk,
  input  logic             s_reset,
  input  logic             enable,
  input  logic             restart,
  input  logic [CNT_W-1:0] period_in,
  input  logic             period_load,
  output logic             tick,
  output logic             ovs_tick,
  output logic [CNT_W-1:0] period_cur,
  output logic             load_pending,
  output logic             period_err
);

  logic [CNT_W-1:0] r_period_cur;
  logic [CNT_W-1:0] r_pending;
  logic             r_load_pending;
  logic             r_period_err;

  logic [CNT_W-1:0] w_period_last;
  logic [OVS_W-1:0] w_ovs_last;
  logic             w_period_at_last;
  logic             w_roll;
  logic             w_ovs_last_unused;
  logic             w_load_valid;
  logic             w_new_avail;
  logic [CNT_W-1:0] w_new_val;
  logic             w_apply_now;

  assign w_period_last = r_period_cur - CNT_W'(1);
  assign w_ovs_last    = OVS_W'(OVS - 1);
  assign w_roll        = enable & ~restart & w_period_at_last;

  mod_counter #(.W(CNT_W)) u_period (
    .i_clk     (clk),
    .i_rst     (s_reset),
    .i_en      (enable),
    .i_clr     (restart),
    .i_last    (w_period_last),
    .o_at_last (w_period_at_last),
    .o_wrap    (tick)
  );

  mod_counter #(.W(OVS_W)) u_ovs (
    .i_clk     (clk),
    .i_rst     (s_reset),
    .i_en      (w_roll),
    .i_clr     (restart),
    .i_last    (w_ovs_last),
    .o_at_last (w_ovs_last_unused),
    .o_wrap    (ovs_tick)
  );

  // A new period may only take over when no period is in flight: restart, freeze or rollover.
  assign w_load_valid = period_load & (period_in >= CNT_W'(MIN_PERIOD));
  assign w_new_avail  = w_load_valid | r_load_pending;
  assign w_new_val    = w_load_valid ? period_in : r_pending;
  assign w_apply_now  = restart | ~enable | w_period_at_last;

  always_ff @(posedge clk or posedge s_reset) begin
    if (s_reset) begin
      r_period_cur   <= CNT_W'(DEFAULT_PERIOD);
      r_pending      <= CNT_W'(DEFAULT_PERIOD);
      r_load_pending <= 1'b0;
      r_period_err   <= 1'b0;
    end else begin
      r_period_err <= period_load & ~w_load_valid;
      if (w_apply_now) begin
        if (w_new_avail) begin
          r_period_cur   <= w_new_val;
          r_pending      <= w_new_val;
          r_load_pending <= 1'b0;
        end
      end else if (w_load_valid) begin
        r_pending      <= period_in;
        r_load_pending <= 1'b1;
      end
    end
  end

  assign period_cur   = r_period_cur;
  assign load_pending = r_load_pending;
  assign period_err   = r_period_err;

endmodule

// File: tb/tb_rate_tick_gen.sv
// Scoreboard bench for rate_tick_gen: stimulus pushes the edge number of every
// expected tick, and a negedge monitor pops and compares whenever tick appears.
module tb_rate_tick_gen;

  localparam int CNT_W = 20;
  localparam int P0    = 434;
  localparam int OVS   = 16;

  logic             clk = 1'b0;
  logic             s_reset = 1'b1;
  logic             enable = 1'b0;
  logic             restart = 1'b0;
  logic             period_load = 1'b0;
  logic [CNT_W-1:0] period_in = '0;
  logic             tick;
  logic             ovs_tick;
  logic [CNT_W-1:0] period_cur;
  logic             load_pending;
  logic             period_err;

  typedef struct {
    int   edgeNo;
    logic ovs;
  } tickExp_t;

  tickExp_t expQ[$];
  int       edgeCount  = 0;
  int       compared   = 0;
  int       mismatched = 0;
  int       tickIdx    = 0;
  int       base       = 0;

  rate_tick_gen #(
    .CNT_W          (CNT_W),
    .DEFAULT_PERIOD (P0),
    .OVS            (OVS),
    .OVS_W          (4)
  ) dut (
    .clk          (clk),
    .s_reset      (s_reset),
    .enable       (enable),
    .restart      (restart),
    .period_in    (period_in),
    .period_load  (period_load),
    .tick         (tick),
    .ovs_tick     (ovs_tick),
    .period_cur   (period_cur),
    .load_pending (load_pending),
    .period_err   (period_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edgeCount <= edgeCount + 1;

  task automatic reportFail(input string name, input logic [31:0] actual, input logic [31:0] expected);
    mismatched++;
    $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", name, actual, expected, edgeCount);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) reportFail(name, actual, expected);
  endtask

  task automatic applyStimulus(input logic en, input logic rs, input logic ld, input logic [CNT_W-1:0] pin);
    enable      = en;
    restart     = rs;
    period_load = ld;
    period_in   = pin;
  endtask

  task automatic pushTick(input int edgeNo);
    tickExp_t e;
    tickIdx++;
    e.edgeNo = edgeNo;
    e.ovs    = ((tickIdx % OVS) == 0);
    expQ.push_back(e);
  endtask

  task automatic waitEdge(input int n);
    while (edgeCount < n) @(negedge clk);
  endtask

  // Monitor: every tick must match the oldest expected entry; overdue entries are misses.
  always @(negedge clk) begin
    tickExp_t e;
    if (!s_reset) begin
      while (expQ.size() > 0 && expQ[0].edgeNo < edgeCount) begin
        e = expQ.pop_front();
        checkOutput("missedTick", edgeCount, e.edgeNo);
      end
      if (tick === 1'b1) begin
        if (expQ.size() == 0) begin
          compared++;
          reportFail("unexpectedTick", edgeCount, 0);
        end else begin
          e = expQ.pop_front();
          checkOutput("tickEdge", edgeCount, e.edgeNo);
          checkOutput("ovsTick", ovs_tick, e.ovs);
        end
      end else begin
        checkOutput("idleOvs", ovs_tick, 0);
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, edge %0d", edgeCount);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    applyStimulus(0, 0, 0, '0);
    repeat (3) @(negedge clk);
    checkOutput("rstTick", tick, 0);
    checkOutput("rstOvs", ovs_tick, 0);
    checkOutput("rstPeriod", period_cur, P0);
    checkOutput("rstPending", load_pending, 0);
    checkOutput("rstErr", period_err, 0);

    // Steady run at the default period for four ovs frames.
    s_reset = 1'b0;
    applyStimulus(1, 0, 0, '0);
    base    = edgeCount;
    tickIdx = 0;
    for (int k = 1; k <= 4 * OVS; k++) pushTick(base + P0 * k);
    waitEdge(base + 4 * OVS * P0);
    base = base + 4 * OVS * P0;

    // Mid-period load of 10 at cnt = 100.
    pushTick(base + P0);
    for (int j = 1; j <= 20; j++) pushTick(base + P0 + 10 * j);
    waitEdge(base + 100);
    applyStimulus(1, 0, 1, 20'd10);
    waitEdge(base + 101);
    applyStimulus(1, 0, 0, '0);
    checkOutput("midLoadPending", load_pending, 1);
    checkOutput("midLoadCurOld", period_cur, P0);
    waitEdge(base + P0);
    checkOutput("midLoadCurNew", period_cur, 10);
    checkOutput("midLoadPendClr", load_pending, 0);
    base = base + P0 + 200;
    waitEdge(base);

    // Back to 434, then a load of 5 strobed exactly on the rollover cycle.
    pushTick(base + 10);
    waitEdge(base + 3);
    applyStimulus(1, 0, 1, 20'd434);
    waitEdge(base + 4);
    applyStimulus(1, 0, 0, '0);
    waitEdge(base + 10);
    checkOutput("restorePeriod", period_cur, P0);
    base = base + 10;
    pushTick(base + P0);
    for (int j = 1; j <= 4; j++) pushTick(base + P0 + 5 * j);
    waitEdge(base + P0 - 1);
    checkOutput("rollPendBefore", load_pending, 0);
    applyStimulus(1, 0, 1, 20'd5);
    waitEdge(base + P0);
    applyStimulus(1, 0, 0, '0);
    checkOutput("rollPendAfter", load_pending, 0);
    checkOutput("rollCur", period_cur, 5);
    base = base + P0 + 20;
    waitEdge(base);

    // Valid pending 20, then rejected loads of 0 and 1.
    pushTick(base + 5);
    pushTick(base + 25);
    pushTick(base + 45);
    applyStimulus(1, 0, 1, 20'd20);
    waitEdge(base + 1);
    applyStimulus(1, 0, 1, 20'd0);
    checkOutput("validPending", load_pending, 1);
    waitEdge(base + 2);
    applyStimulus(1, 0, 0, '0);
    checkOutput("errZero", period_err, 1);
    checkOutput("errZeroKeeps", load_pending, 1);
    checkOutput("errZeroCur", period_cur, 5);
    waitEdge(base + 3);
    applyStimulus(1, 0, 1, 20'd1);
    checkOutput("errGap", period_err, 0);
    waitEdge(base + 4);
    applyStimulus(1, 0, 0, '0);
    checkOutput("errOne", period_err, 1);
    checkOutput("errOneKeeps", load_pending, 1);
    waitEdge(base + 5);
    checkOutput("errCleared", period_err, 0);
    checkOutput("pendingApplied", period_cur, 20);
    checkOutput("pendingClr", load_pending, 0);
    base = base + 45;
    waitEdge(base);

    // Restore 434, then freeze for 50 cycles at cnt = 200.
    pushTick(base + 20);
    waitEdge(base + 1);
    applyStimulus(1, 0, 1, 20'd434);
    waitEdge(base + 2);
    applyStimulus(1, 0, 0, '0);
    waitEdge(base + 20);
    checkOutput("restore2", period_cur, P0);
    base = base + 20;
    pushTick(base + 484);
    waitEdge(base + 200);
    applyStimulus(0, 0, 0, '0);
    waitEdge(base + 250);
    applyStimulus(1, 0, 0, '0);
    waitEdge(base + 484);
    base = base + 484;

    // Restart while frozen clears both counters.
    waitEdge(base + 50);
    applyStimulus(0, 1, 0, '0);
    waitEdge(base + 51);
    applyStimulus(1, 0, 0, '0);
    checkOutput("restartTick", tick, 0);
    checkOutput("restartOvs", ovs_tick, 0);
    tickIdx = 0;
    base = base + 51;
    pushTick(base + P0);
    pushTick(base + 2 * P0);
    waitEdge(base + 2 * P0);
    base = base + 2 * P0;

    // Asynchronous reset at cnt = 300 with a load pending.
    waitEdge(base + 100);
    applyStimulus(1, 0, 1, 20'd50);
    waitEdge(base + 101);
    applyStimulus(1, 0, 0, '0);
    checkOutput("preRstPending", load_pending, 1);
    waitEdge(base + 300);
    #2 s_reset = 1'b1;
    #1;
    checkOutput("asyncTick", tick, 0);
    checkOutput("asyncOvs", ovs_tick, 0);
    checkOutput("asyncPending", load_pending, 0);
    checkOutput("asyncErr", period_err, 0);
    checkOutput("asyncPeriod", period_cur, P0);
    repeat (2) @(negedge clk);
    s_reset = 1'b0;
    base    = edgeCount;
    tickIdx = 0;
    pushTick(base + P0);
    waitEdge(base + P0 + 2);
    checkOutput("queueDrained", expQ.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
